// File: rtl/ft245_pkg.sv
// Shared types and header layout for the FT245 channel multiplexer.
package ft245_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CH_HI  = 7;
    localparam int unsigned CH_LO  = 6;
    localparam int unsigned LEN_HI = 5;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_DATA = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_HDR  = 1'b0,
        RX_DATA = 1'b1
    } rx_state_e;

    // Burst header: channel in the top bits, payload length-1 below.
    function automatic logic [BYTE_W-1:0] mk_hdr(input logic [CH_W-1:0]  ch,
                                                 input logic [LEN_W-1:0] len);
        logic [BYTE_W-1:0] h;
        h               = '0;
        h[CH_HI:CH_LO]  = ch;
        h[LEN_HI:0]     = len;
        return h;
    endfunction

endpackage

// File: rtl/ft245_chan_mux_if.sv
// Channel-side and FT245-side streams of the multiplexer.
interface ft245_chan_mux_if;
    import ft245_pkg::*;

    logic [NUM_CH-1:0]        tx_req_i;
    logic [NUM_CH*LEN_W-1:0]  tx_len_i;
    logic [NUM_CH-1:0]        tx_gnt_o;
    logic [NUM_CH-1:0]        tx_valid_i;
    logic [NUM_CH*BYTE_W-1:0] tx_data_i;
    logic [NUM_CH-1:0]        tx_accept_o;

    logic                     ft_tx_valid_o;
    logic [BYTE_W-1:0]        ft_tx_data_o;
    logic                     ft_tx_accept_i;

    logic                     ft_rx_valid_i;
    logic [BYTE_W-1:0]        ft_rx_data_i;
    logic                     ft_rx_accept_o;

    logic [NUM_CH-1:0]        rx_valid_o;
    logic [BYTE_W-1:0]        rx_data_o;
    logic                     rx_last_o;
    logic [NUM_CH-1:0]        rx_accept_i;
    logic [NUM_CH-1:0]        rx_en_i;
    logic                     rx_timeout_o;

    modport slave (
        input  tx_req_i, tx_len_i, tx_valid_i, tx_data_i, ft_tx_accept_i,
               ft_rx_valid_i, ft_rx_data_i, rx_accept_i, rx_en_i,
        output tx_gnt_o, tx_accept_o, ft_tx_valid_o, ft_tx_data_o,
               ft_rx_accept_o, rx_valid_o, rx_data_o, rx_last_o, rx_timeout_o
    );

    modport master (
        output tx_req_i, tx_len_i, tx_valid_i, tx_data_i, ft_tx_accept_i,
               ft_rx_valid_i, ft_rx_data_i, rx_accept_i, rx_en_i,
        input  tx_gnt_o, tx_accept_o, ft_tx_valid_o, ft_tx_data_o,
               ft_rx_accept_o, rx_valid_o, rx_data_o, rx_last_o, rx_timeout_o
    );

endinterface

// File: rtl/ft245_rr_arb.sv
// 4-way round-robin pick: first requester strictly after the last winner.
module ft245_rr_arb
    import ft245_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o
);

    logic [CH_W-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = ptr_i + CH_W'(i);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/ft245_chan_mux.sv
// Multiplexes four channel byte streams onto one FT245 FIFO pair using
// header-prefixed bursts; TX and RX run independently.
module ft245_chan_mux
    import ft245_pkg::*;
#(
    parameter logic [15:0] RX_TIMEOUT = 16'd4096
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    ft245_chan_mux_if.slave  bus
);

    logic [LEN_W-1:0]  len_arr [NUM_CH];
    logic [BYTE_W-1:0] dat_arr [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign len_arr[c] = bus.tx_len_i[c*LEN_W +: LEN_W];
        assign dat_arr[c] = bus.tx_data_i[c*BYTE_W +: BYTE_W];
    end

    tx_state_e         tx_q;
    logic [CH_W-1:0]   tx_ch_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [LEN_W-1:0]  tx_len_q;
    logic [LEN_W-1:0]  tx_cnt_q;
    logic [NUM_CH-1:0] tx_gnt_q;
    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              tx_hs_c;

    ft245_rr_arb u_arb (
        .req_i (bus.tx_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign tx_hs_c      = (tx_q == TX_DATA) && bus.tx_valid_i[tx_ch_q] && bus.ft_tx_accept_i;
    assign bus.tx_gnt_o = tx_gnt_q;

    // TX burst sequencer; pointer starts at the last channel so ch0 wins first.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_q     <= TX_IDLE;
            tx_ch_q  <= '0;
            tx_len_q <= '0;
            tx_cnt_q <= '0;
            tx_gnt_q <= '0;
            rr_ptr_q <= CH_W'(NUM_CH - 1);
        end else begin
            case (tx_q)
                TX_IDLE: if (|bus.tx_req_i) begin
                    tx_ch_q  <= arb_idx;
                    tx_len_q <= len_arr[arb_idx];
                    tx_gnt_q <= arb_gnt;
                    tx_q     <= TX_HDR;
                end
                TX_HDR: if (bus.ft_tx_accept_i) begin
                    tx_cnt_q <= tx_len_q;
                    tx_q     <= TX_DATA;
                end
                TX_DATA: if (tx_hs_c) begin
                    if (tx_cnt_q == '0) begin
                        tx_q     <= TX_IDLE;
                        tx_gnt_q <= '0;
                        rr_ptr_q <= tx_ch_q;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - LEN_W'(1);
                    end
                end
                default: tx_q <= TX_IDLE;
            endcase
        end
    end

    // Payload is a direct passthrough of the granted channel.
    always_comb begin
        bus.ft_tx_valid_o = 1'b0;
        bus.ft_tx_data_o  = '0;
        bus.tx_accept_o   = '0;
        case (tx_q)
            TX_HDR: begin
                bus.ft_tx_valid_o = 1'b1;
                bus.ft_tx_data_o  = mk_hdr(tx_ch_q, tx_len_q);
            end
            TX_DATA: begin
                bus.ft_tx_valid_o        = bus.tx_valid_i[tx_ch_q];
                bus.ft_tx_data_o         = dat_arr[tx_ch_q];
                bus.tx_accept_o[tx_ch_q] = bus.ft_tx_accept_i;
            end
            default: ;
        endcase
    end

    rx_state_e        rx_q;
    logic [CH_W-1:0]  rx_ch_q;
    logic [LEN_W-1:0] rx_cnt_q;
    logic             rx_en_q;
    logic [15:0]      rx_idle_q;
    logic             rx_tmo_q;
    logic             run_q;
    logic             rx_acc_c;
    logic             rx_hs_c;

    // run_q keeps the header accept low until the first cycle out of reset.
    always_comb begin
        rx_acc_c       = 1'b0;
        bus.rx_valid_o = '0;
        bus.rx_data_o  = '0;
        if (rx_q == RX_HDR) begin
            rx_acc_c = run_q;
        end else if (rx_en_q) begin
            rx_acc_c                = bus.rx_accept_i[rx_ch_q];
            bus.rx_valid_o[rx_ch_q] = bus.ft_rx_valid_i;
            bus.rx_data_o           = bus.ft_rx_data_i;
        end else begin
            rx_acc_c = 1'b1;
        end
    end

    assign rx_hs_c            = bus.ft_rx_valid_i && rx_acc_c;
    assign bus.ft_rx_accept_o = rx_acc_c;
    assign bus.rx_last_o      = (rx_q == RX_DATA) && (rx_cnt_q == '0);
    assign bus.rx_timeout_o   = rx_tmo_q;

    // RX parser with an idle-gap watchdog inside each burst.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_q      <= RX_HDR;
            rx_ch_q   <= '0;
            rx_cnt_q  <= '0;
            rx_en_q   <= 1'b0;
            rx_idle_q <= '0;
            rx_tmo_q  <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            rx_tmo_q <= 1'b0;
            case (rx_q)
                RX_HDR: begin
                    rx_idle_q <= '0;
                    if (rx_hs_c) begin
                        rx_ch_q  <= bus.ft_rx_data_i[CH_HI:CH_LO];
                        rx_cnt_q <= bus.ft_rx_data_i[LEN_HI:0];
                        rx_en_q  <= bus.rx_en_i[bus.ft_rx_data_i[CH_HI:CH_LO]];
                        rx_q     <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bus.ft_rx_valid_i) begin
                        rx_idle_q <= '0;
                        if (rx_hs_c) begin
                            if (rx_cnt_q == '0) rx_q <= RX_HDR;
                            else                rx_cnt_q <= rx_cnt_q - LEN_W'(1);
                        end
                    end else if (rx_idle_q == RX_TIMEOUT - 16'd1) begin
                        rx_idle_q <= '0;
                        rx_tmo_q  <= 1'b1;
                        rx_q      <= RX_HDR;
                    end else begin
                        rx_idle_q <= rx_idle_q + 16'd1;
                    end
                end
                default: rx_q <= RX_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_chan_mux.sv
// Randomized bench for ft245_chan_mux against a burst-level reference model.
module tb_ft245_chan_mux;
    import ft245_pkg::*;

    localparam logic [15:0] TMO = 16'd40;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ft245_chan_mux_if bus ();

    ft245_chan_mux #(.RX_TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  srcq [4][$];
    logic [9:0]  txexp [$];
    logic [10:0] rxexp [$];
    logic [7:0]  rxq [$];

    logic [3:0] req_mask = '0;
    logic [5:0] lens [4];
    logic [3:0] rx_en = '0;
    int  model_ptr = 3;
    int  bursts_goal = 0;
    int  grants_seen = 0;
    int  gap = 0;
    logic [3:0] gnt_prev = '0;
    int  tx_acc_mode = 1;
    int  rx_acc_mode = 1;
    bit  tx_gaps = 0;
    bit  rx_gaps = 0;
    bit  tmo_skip = 0;
    logic tmo_s, tx_v_s;
    logic [7:0] tx_d_s;
    logic [3:0] gnt_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {bus.tx_gnt_o, bus.ft_tx_valid_o, bus.ft_tx_data_o, bus.tx_accept_o,
                bus.ft_rx_accept_o, bus.rx_valid_o, bus.rx_data_o, bus.rx_last_o,
                bus.rx_timeout_o};
    endfunction

    // Channel chosen next: the requester with the smallest distance after 'last'.
    function automatic int next_ch(input logic [3:0] mask, input int last);
        int best = 0;
        int best_d = 4;
        for (int c = 0; c < 4; c++) begin
            int d = (c - last + 3) % 4;
            if (mask[c] && d < best_d) begin
                best = c;
                best_d = d;
            end
        end
        return best;
    endfunction

    function automatic int pending();
        return txexp.size() + rxexp.size() + rxq.size() +
               srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size();
    endfunction

    task automatic sample();
        logic [9:0]  te;
        logic [10:0] re;
        if (bus.tx_gnt_o != 4'b0 && gnt_prev == 4'b0) begin
            if (grants_seen > 0) chk("tx_idle_gap", 32'(gap), 32'd1);
            grants_seen++;
        end
        if (bus.tx_gnt_o == 4'b0) gap++;
        else gap = 0;
        gnt_prev = bus.tx_gnt_o;

        if (bus.ft_tx_valid_o && bus.ft_tx_accept_i) begin
            if (txexp.size() == 0) begin
                chk("tx_extra_byte", 32'(bus.ft_tx_valid_o), 32'd0);
            end else begin
                te = txexp.pop_front();
                chk("tx_byte", 32'(bus.ft_tx_data_o), 32'(te[7:0]));
                chk("tx_gnt", 32'(bus.tx_gnt_o), 32'(4'b1 << te[9:8]));
                chk("tx_acc_other", 32'(bus.tx_accept_o & ~bus.tx_gnt_o), 32'd0);
            end
        end
        for (int c = 0; c < 4; c++)
            if (bus.tx_valid_i[c] && bus.tx_accept_o[c] && srcq[c].size() > 0)
                void'(srcq[c].pop_front());

        if (bus.ft_rx_valid_i)
            chk("rx_valid_disabled", 32'(bus.rx_valid_o & ~bus.rx_en_i), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (bus.rx_valid_o[c] && bus.rx_accept_i[c]) begin
                if (rxexp.size() == 0) begin
                    chk("rx_extra_beat", 32'(bus.rx_valid_o[c]), 32'd0);
                end else begin
                    re = rxexp.pop_front();
                    chk("rx_beat", 32'({2'(c), bus.rx_last_o, bus.rx_data_o}), 32'(re));
                end
            end
        end
        if (bus.ft_rx_valid_i && bus.ft_rx_accept_o && rxq.size() > 0)
            void'(rxq.pop_front());

        tmo_s  = bus.rx_timeout_o;
        tx_v_s = bus.ft_tx_valid_o;
        tx_d_s = bus.ft_tx_data_o;
        gnt_s  = bus.tx_gnt_o;
        if (!tmo_skip) chk("rx_tmo_spurious", 32'(bus.rx_timeout_o), 32'd0);
    endtask

    task automatic step();
        logic [3:0] v;
        @(negedge clk);
        bus.tx_req_i = (grants_seen < bursts_goal) ? req_mask : 4'b0;
        bus.tx_len_i = {lens[3], lens[2], lens[1], lens[0]};
        for (int c = 0; c < 4; c++) begin
            v[c] = (srcq[c].size() > 0) && (!tx_gaps || $urandom_range(0, 3) != 0);
            bus.tx_data_i[c*8 +: 8] = (srcq[c].size() > 0) ? srcq[c][0] : 8'($urandom);
        end
        bus.tx_valid_i     = v;
        bus.ft_tx_accept_i = (tx_acc_mode == 2) ? 1'($urandom) : 1'(tx_acc_mode);
        bus.ft_rx_valid_i  = (rxq.size() > 0) && (!rx_gaps || $urandom_range(0, 3) != 0);
        bus.ft_rx_data_i   = (rxq.size() > 0) ? rxq[0] : 8'($urandom);
        bus.rx_accept_i    = (rx_acc_mode == 2) ? 4'($urandom) : 4'b1111;
        bus.rx_en_i        = rx_en;
        #1;
        sample();
        @(posedge clk);
    endtask

    task automatic start_tx(input logic [3:0] mask, input int nb, input int len_fix, input int base);
        int ch;
        int k = 0;
        logic [7:0] b;
        req_mask    = mask;
        bursts_goal = nb;
        grants_seen = 0;
        for (int c = 0; c < 4; c++)
            lens[c] = (len_fix >= 0) ? 6'(len_fix) : 6'($urandom_range(0, 7));
        for (int n = 0; n < nb; n++) begin
            ch = next_ch(mask, model_ptr);
            model_ptr = ch;
            txexp.push_back({2'(ch), 2'(ch), lens[ch]});
            for (int i = 0; i <= int'(lens[ch]); i++) begin
                b = (base >= 0) ? 8'(base + k) : 8'($urandom);
                k++;
                srcq[ch].push_back(b);
                txexp.push_back({2'(ch), b});
            end
        end
    endtask

    task automatic send_pkt(input int ch, input int len, input int nsend, input int base, input int stride);
        logic [7:0] b;
        rxq.push_back({2'(ch), 6'(len)});
        for (int i = 0; i < nsend; i++) begin
            b = (base >= 0) ? 8'(base + i * stride) : 8'($urandom);
            rxq.push_back(b);
            if (rx_en[ch]) rxexp.push_back({2'(ch), 1'(i == len), b});
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(pending()), 32'd0);
    endtask

    initial begin
        int seen;
        for (int c = 0; c < 4; c++) lens[c] = '0;
        bus.tx_req_i = '0; bus.tx_len_i = '0; bus.tx_valid_i = '0; bus.tx_data_i = '0;
        bus.ft_tx_accept_i = 1'b0; bus.ft_rx_valid_i = 1'b0; bus.ft_rx_data_i = '0;
        bus.rx_accept_i = '0; bus.rx_en_i = '0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("reset_outputs", outs(), 32'd0);
        @(negedge clk); rstn = 1'b1;

        // All channels, len 0: headers rotate 00,40,80,C0 from ch0
        tx_acc_mode = 1; tx_gaps = 0;
        start_tx(4'b1111, 8, 0, 8'h10);
        drain("drain_rr_all", 200);

        // Single channel ch2, len 3, payload AA..AD
        start_tx(4'b0100, 1, 3, 8'hAA);
        drain("drain_ch2", 100);
        step(); step();
        chk("tx_back_idle_gnt", 32'(gnt_s), 32'd0);
        chk("tx_back_idle_valid", 32'(tx_v_s), 32'd0);

        // RX ch1: 0x41, 11, 22
        rx_en = 4'b0010; rx_acc_mode = 1; rx_gaps = 0;
        send_pkt(1, 1, 2, 8'h11, 8'h11);
        drain("drain_rx_ch1", 50);

        // RX ch3 disabled: payload swallowed, then a ch1 packet parses normally
        send_pkt(3, 1, 2, -1, 0);
        send_pkt(1, 2, 3, -1, 0);
        drain("drain_rx_discard", 50);

        // RX timeout mid-burst, then 0x00 parsed as a header
        rx_en = 4'b0001; tmo_skip = 1;
        send_pkt(0, 5, 2, 8'h5A, 1);
        drain("drain_rx_partial", 50);
        seen = 0;
        for (int i = 0; i < int'(TMO); i++) begin
            step();
            seen = seen | int'(tmo_s);
        end
        chk("rx_tmo_early", 32'(seen), 32'd0);
        step(); chk("rx_tmo_pulse", 32'(tmo_s), 32'd1);
        step(); chk("rx_tmo_one_cycle", 32'(tmo_s), 32'd0);
        tmo_skip = 0;
        send_pkt(0, 0, 1, 8'h77, 0);
        drain("drain_rx_after_tmo", 50);

        // Random concurrent TX and RX traffic
        tx_acc_mode = 2; tx_gaps = 1; rx_acc_mode = 2; rx_gaps = 1;
        for (int r = 0; r < 6; r++) begin
            rx_en = 4'($urandom);
            start_tx(4'($urandom_range(1, 15)), 5, -1, -1);
            for (int p = 0; p < 5; p++) begin
                int len = $urandom_range(0, 7);
                send_pkt($urandom_range(0, 3), len, len + 1, -1, 0);
            end
            drain("drain_random", 3000);
        end

        // TX stall of 10 cycles mid-burst, then reset mid-burst
        tx_acc_mode = 1; tx_gaps = 0; rx_gaps = 0; rx_acc_mode = 1;
        start_tx(4'b0010, 1, 7, 8'h30);
        seen = 0;
        while (txexp.size() > 6 && seen < 50) begin
            step();
            seen++;
        end
        chk("tx_pre_stall_left", 32'(txexp.size()), 32'd6);
        tx_acc_mode = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("tx_stall_valid", 32'(tx_v_s), 32'd1);
            chk("tx_stall_data", 32'(tx_d_s), 32'(txexp[0][7:0]));
        end
        chk("tx_stall_no_loss", 32'(txexp.size()), 32'd6);
        tx_acc_mode = 1;
        step();
        chk("tx_post_stall_left", 32'(txexp.size()), 32'd5);
        @(negedge clk); rstn = 1'b0; #1;
        chk("midburst_reset_outputs", outs(), 32'd0);
        txexp.delete();
        for (int c = 0; c < 4; c++) srcq[c].delete();
        bursts_goal = 0; grants_seen = 0; model_ptr = 3;
        step(); step();
        chk("reset_hold_outputs", outs(), 32'd0);
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_reset_quiet", 32'({gnt_s, tx_v_s}), 32'd0);
        end

        // After reset ch0 wins first again
        tx_acc_mode = 2;
        start_tx(4'b1111, 4, 0, 8'hC0);
        drain("drain_post_reset_rr", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft245_chan_mux.md
FT245_CHAN_MUX -- requirements
Module: ft245_chan_mux

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter RX_TIMEOUT, default 16'd4096, the idle cycles inside an RX burst before abort.
REQ-003 SHALL have port clk_i  in  1  clock.
REQ-004 SHALL have port rstn_i  in  1  async active-low reset.
REQ-005 SHALL have port tx_req_i  in  4  per-channel burst request.
REQ-006 SHALL have port tx_len_i  in  24  per-channel burst length-1, 6 bits each, ch0 in [5:0].
REQ-007 SHALL have port tx_gnt_o  out  4  one-hot grant, held for the whole burst.
REQ-008 SHALL have port tx_valid_i / tx_data_i / tx_accept_o  in/in/out  4/32/4  per-channel TX byte streams.
REQ-009 SHALL have port ft_tx_valid_o / ft_tx_data_o / ft_tx_accept_i  out/out/in  1/8/1  byte stream into the FT245 FIFO inport.
REQ-010 SHALL have port ft_rx_valid_i / ft_rx_data_i / ft_rx_accept_o  in/in/out  1/8/1  byte stream from the FT245 FIFO outport.
REQ-011 SHALL have port rx_valid_o / rx_data_o / rx_last_o / rx_accept_i  out/out/out/in  4/8/1/4  per-channel RX streams (data and last shared).
REQ-012 SHALL have port rx_en_i  in  4  per-channel RX enable.
REQ-013 SHALL have port rx_timeout_o  out  1  one-cycle pulse on RX burst abort.

Function
REQ-014 SHALL prefix every burst in each direction with a header byte: [7:6] = channel, [5:0] = length-1 (1..64 payload bytes).
REQ-015 SHALL run the TX FSM through IDLE, HDR and DATA:
- IDLE: when any tx_req_i is set, pick round-robin starting after the last granted channel, latch channel and tx_len_i, and go to HDR next cycle.
- HDR: ft_tx_valid_o=1 with data = header; on ft_tx_accept_i go to DATA with count = len.
- DATA: ft_tx_valid_o = tx_valid_i[ch]; tx_accept_o[ch] = ft_tx_accept_i; ft_tx_data_o = tx_data_i[ch] (combinational passthrough).
- DATA: each handshake decrements count; the handshake at count==0 returns to IDLE and updates the round-robin pointer.
REQ-016 SHALL drive tx_gnt_o[ch] in HDR and DATA only, and hold tx_accept_o low for every non-granted channel.
REQ-017 SHALL require tx_req_i and tx_len_i to be stable until grant; tx_req_i changes after grant SHALL be ignored until IDLE.
REQ-018 SHALL insert exactly one IDLE cycle between back-to-back TX bursts.
REQ-019 SHALL run the RX FSM through HDR and DATA:
- HDR: ft_rx_accept_o=1; a valid byte latches channel and count = length-1, then go to DATA.
- DATA with rx_en_i[ch]=1: rx_valid_o[ch] = ft_rx_valid_i; ft_rx_accept_o = rx_accept_i[ch]; rx_data_o = ft_rx_data_i.
- DATA with rx_en_i[ch]=0 (sampled at header): ft_rx_accept_o=1 and rx_valid_o stays 0, so payload is discarded.
- DATA: rx_last_o=1 while count==0; a handshake at count==0 returns to HDR.
REQ-020 SHALL count RX DATA cycles with ft_rx_valid_i=0, clearing the count on any valid byte.
REQ-021 SHALL, when that count reaches RX_TIMEOUT, return the RX FSM to HDR and pulse rx_timeout_o for one cycle.
REQ-022 SHALL run the TX and RX FSMs independently; simultaneous activity SHALL not stall either.
REQ-023 SHALL wrap the round-robin pointer modulo 4 and the byte counters within 6 bits, with no overflow past 0.

Reset
REQ-024 SHALL, while rstn_i=0, set all outputs to 0, the TX FSM to IDLE, the RX FSM to HDR and the round-robin pointer to 3, so ch0 wins first.
REQ-025 SHALL, on reset mid-burst, abandon the burst immediately; no partial header or data is re-emitted after release.

Structure
REQ-026 SHALL place the FSM state encodings, header field positions (CH_HI=7, CH_LO=6, LEN_HI=5) and NUM_CH=4 in shared package ft245_pkg.
REQ-027 SHALL implement channel selection in one sub-module, ft245_rr_arb (4-way round-robin, request/pointer in, one-hot grant out).

Verification
REQ-028 SHALL cover: ch2 only, tx_len=3, 4 bytes AA..AD -> ft_tx stream 0x83,AA,AB,AC,AD; tx_gnt_o=4'b0100 throughout; then IDLE.
REQ-029 SHALL cover: all 4 channels request, len=0 -> headers 0x00,0x40,0x80,0xC0 in order, repeating fairly on continued requests.
REQ-030 SHALL cover: ft_rx bytes 0x41,11,22 with rx_en_i=4'b0010 -> rx_valid_o[1] for 11,22; rx_last_o only with 22.
REQ-031 SHALL cover: header 0xC1 with rx_en_i[3]=0 -> 2 payload bytes consumed, rx_valid_o=0, FSM back to HDR.
REQ-032 SHALL cover: RX header 0x05, 2 bytes, then idle for RX_TIMEOUT cycles -> rx_timeout_o pulse; next byte 0x00 parsed as a header.
REQ-033 SHALL cover: ft_tx_accept_i low 10 cycles during DATA plus rstn_i low mid-burst -> no byte lost before reset; all outputs 0 during reset.
